axi_datamover_s2mm_model: RTL

//  Responder end of the DataMover S2MM command/data/status streams that axi_datamover_write drives.

---
 rtl/axi_datamover_s2mm_model.sv | 112 +++++++++++
 1 files changed

// File: rtl/axi_datamover_s2mm_model.sv
// axi_datamover_s2mm_model: S2MM command/data/status responder backed by a byte-enabled RAM
module axi_datamover_s2mm_model #(
  parameter int DATA_WIDTH = 64,
  parameter int CMD_WIDTH  = 72,
  parameter int ADDR_WIDTH = 32,
  parameter int STS_WIDTH  = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int BTT_WIDTH  = 23
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [CMD_WIDTH-1:0]         s2mm_cmd_tdata,
  input  logic                         s2mm_cmd_tvalid,
  output logic                         s2mm_cmd_tready,
  input  logic [DATA_WIDTH-1:0]        s2mm_tdata,
  input  logic [DATA_WIDTH/8-1:0]      s2mm_tkeep,
  input  logic                         s2mm_tlast,
  input  logic                         s2mm_tvalid,
  output logic                         s2mm_tready,
  output logic [STS_WIDTH-1:0]         s2mm_sts_tdata,
  output logic [STS_WIDTH/8-1:0]       s2mm_sts_tkeep,
  output logic                         s2mm_sts_tlast,
  output logic                         s2mm_sts_tvalid,
  input  logic                         s2mm_sts_tready,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0]        mem_rdata
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int SH = $clog2(KW);
  localparam int PW = $clog2(KW + 1);
  typedef enum logic [1:0] {IDLE, DATA, STS} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] ptr;
  logic [BTT_WIDTH-1:0]  btt;
  logic [3:0]            tag;
  logic [BTT_WIDTH:0]    cnt, cnt_n;
  logic [PW-1:0]         pop;
  logic                  decerr, dec_n, in_range, cmd_hs, beat_hs, sts_hs, term;
  logic [BTT_WIDTH-1:0]  cmd_btt;
  logic [3:0]            cmd_tag;
  logic [ADDR_WIDTH-1:0] cmd_saddr;
  logic                  unused_cmd;
  assign cmd_btt         = s2mm_cmd_tdata[BTT_WIDTH-1:0];
  assign cmd_tag         = s2mm_cmd_tdata[67:64];
  assign cmd_saddr       = s2mm_cmd_tdata[32 +: ADDR_WIDTH];
  assign unused_cmd      = ^{s2mm_cmd_tdata[CMD_WIDTH-1:68], s2mm_cmd_tdata[31:BTT_WIDTH]};
  assign cmd_hs          = s2mm_cmd_tvalid & s2mm_cmd_tready;
  assign beat_hs         = s2mm_tvalid & s2mm_tready;
  assign sts_hs          = s2mm_sts_tvalid & s2mm_sts_tready;
  assign in_range        = ptr < ADDR_WIDTH'(MEM_DEPTH);
  assign dec_n           = decerr | ~in_range;
  assign cnt_n           = cnt + (BTT_WIDTH+1)'(pop);
  assign term            = beat_hs & (s2mm_tlast | (cnt_n >= {1'b0, btt}));
  assign s2mm_sts_tkeep  = '1;
  assign s2mm_sts_tlast  = s2mm_sts_tvalid;
  // count enabled bytes of the current beat
  always_comb begin
    pop = '0;
    for (int i = 0; i < KW; i++) pop = pop + PW'(s2mm_tkeep[i]);
  end
  // next-state: command -> data (or straight to status on BTT=0) -> status -> idle
  always_comb begin
    state_n = state;
    if (state == IDLE && cmd_hs) state_n = (cmd_btt == '0) ? STS : DATA;
    if (state == DATA && term) state_n = STS;
    if (state == STS && sts_hs) state_n = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_n;
  // registered handshakes, transfer bookkeeping, status word and backdoor read
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s2mm_cmd_tready <= 1'b0;
      s2mm_tready     <= 1'b0;
      s2mm_sts_tvalid <= 1'b0;
      s2mm_sts_tdata  <= '0;
      mem_rdata       <= '0;
      ptr             <= '0;
      btt             <= '0;
      tag             <= '0;
      cnt             <= '0;
      decerr          <= 1'b0;
    end else begin
      s2mm_cmd_tready <= state_n == IDLE;
      s2mm_tready     <= state_n == DATA;
      s2mm_sts_tvalid <= state_n == STS;
      mem_rdata       <= mem[mem_raddr];
      if (cmd_hs) begin
        btt    <= cmd_btt;
        tag    <= cmd_tag;
        ptr    <= cmd_saddr >> SH;
        cnt    <= '0;
        decerr <= 1'b0;
      end
      if (beat_hs) begin
        cnt    <= cnt_n;
        ptr    <= ptr + ADDR_WIDTH'(1);
        decerr <= dec_n;
      end
      if (cmd_hs && cmd_btt == '0) s2mm_sts_tdata <= STS_WIDTH'({1'b1, cmd_tag});
      if (term) s2mm_sts_tdata <= STS_WIDTH'({s2mm_tlast, cnt_n[BTT_WIDTH-1:0], ~dec_n, 1'b0, dec_n, 1'b0, tag});
    end
  // byte-enabled RAM write; contents survive reset
  always_ff @(posedge clk)
    if (beat_hs && in_range)
      for (int i = 0; i < KW; i++)
        if (s2mm_tkeep[i]) mem[ptr[AW-1:0]][i*8 +: 8] <= s2mm_tdata[i*8 +: 8];
endmodule
